// File: rtl/lsu_align_unit.sv
// lsu_align_unit: load/store alignment between memory stage and data port.
// Define LSU_MISALIGN_SPLIT_EN to split misaligned accesses into two beats.
module lsu_align_unit #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WIDTH-1:0]  req_wdata,
  output logic              rsp_valid,
  output logic [WIDTH-1:0]  rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH/8-1:0] mem_be,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic              mem_rvalid,
  input  logic [WIDTH-1:0]  mem_rdata
);
  localparam int NB = WIDTH / 8;
  localparam int OW = $clog2(NB);
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif
  typedef enum logic [2:0] {
    IDLE, REQ0, WAIT0,
`ifdef LSU_MISALIGN_SPLIT_EN
    REQ1, WAIT1,
`endif
    RESP
  } state_t;
  state_t state, nxt;
  logic              lat_store, lat_split;
  logic [2:0]        lat_f3;
  logic [ADDR_W-1:0] lat_addr;
  logic [WIDTH-1:0]  lat_wdata, d0;
  logic              src_store;
  logic [2:0]        src_f3;
  logic [ADDR_W-1:0] src_addr, addr0, addr1;
  logic [WIDTH-1:0]  src_wdata, hi, lo, raw, lft, ext;
  logic signed [WIDTH-1:0] sext;
  logic [OW-1:0]     off;
  logic [3:0]        nbytes;
  logic [7:0]        sh;
  logic              mis, bad;
  logic [2*NB-1:0]   bsh;
  logic [2*WIDTH-1:0] wsh;
  // Fields come straight from the request while idle, from the latch afterwards.
  always_comb begin
    src_store = (state == IDLE) ? req_store  : lat_store;
    src_f3    = (state == IDLE) ? req_funct3 : lat_f3;
    src_addr  = (state == IDLE) ? req_addr   : lat_addr;
    src_wdata = (state == IDLE) ? req_wdata  : lat_wdata;
    off       = src_addr[OW-1:0];
    nbytes    = 4'd1 << src_f3[1:0];
    mis       = (5'(off) + 5'(nbytes)) > 5'(NB);
    bad       = (WIDTH == 32 && src_f3[1:0] == 2'b11)
             || (!src_store && src_f3[2:1] == 2'b11 && (WIDTH == 32 || src_f3[0]))
             || (src_store && src_f3[2])
             || (mis && !SPLIT);
    bsh       = (((2*NB)'(1) << nbytes) - (2*NB)'(1)) << off;
    wsh       = {{WIDTH{1'b0}}, src_wdata} << {off, 3'b000};
    addr0     = {src_addr[ADDR_W-1:OW], {OW{1'b0}}};
    addr1     = addr0 + ADDR_W'(NB);
    hi        = lat_split ? mem_rdata : '0;
    lo        = lat_split ? d0 : mem_rdata;
    raw       = WIDTH'({hi, lo} >> {off, 3'b000});
    sh        = 8'(WIDTH) - {1'b0, nbytes, 3'b000};
    lft       = raw << sh;
    sext      = $signed(lft) >>> sh;
    ext       = src_f3[2] ? lft >> sh : sext;
  end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else       state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  nxt = req_valid ? (bad ? RESP : REQ0) : IDLE;
      REQ0:  nxt = mem_gnt ? WAIT0 : REQ0;
`ifdef LSU_MISALIGN_SPLIT_EN
      WAIT0: nxt = mem_rvalid ? (lat_split ? REQ1 : RESP) : WAIT0;
      REQ1:  nxt = mem_gnt ? WAIT1 : REQ1;
      WAIT1: nxt = mem_rvalid ? RESP : WAIT1;
`else
      WAIT0: nxt = mem_rvalid ? RESP : WAIT0;
`endif
      RESP:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    req_ready = state == IDLE;
    rsp_valid = state == RESP;
`ifdef LSU_MISALIGN_SPLIT_EN
    mem_req   = state == REQ0 || state == REQ1;
`else
    mem_req   = state == REQ0;
`endif
  end
  always_ff @(posedge clk)
    if (reset) begin
      lat_store <= 1'b0;
      lat_split <= 1'b0;
      lat_f3    <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      d0        <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        lat_store <= req_store;
        lat_f3    <= req_funct3;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_split <= SPLIT && mis;
      end
      if (state == WAIT0 && mem_rvalid) d0 <= mem_rdata;
      // Beat 1 is loaded on the WAIT0 exit of a split access.
      if ((state == IDLE && nxt == REQ0) || (state == WAIT0 && mem_rvalid && lat_split)) begin
        mem_we    <= src_store;
        mem_addr  <= (state == WAIT0) ? addr1 : addr0;
        mem_be    <= (state == WAIT0) ? bsh[2*NB-1:NB] : bsh[NB-1:0];
        mem_wdata <= (state == WAIT0) ? wsh[2*WIDTH-1:WIDTH] : wsh[WIDTH-1:0];
      end else if (mem_req && mem_gnt) begin
        mem_we    <= 1'b0;
        mem_addr  <= '0;
        mem_be    <= '0;
        mem_wdata <= '0;
      end
      if (nxt == RESP && state != RESP) begin
        rsp_err   <= state == IDLE;
        rsp_rdata <= (state == IDLE || lat_store) ? '0 : ext;
      end
    end
endmodule
